serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: x - y - bin -> difference d, borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a single
// full-subtractor slice; reports difference, final borrow and signed overflow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  logic fs_d;
  logic fs_bo;
  logic last_bit;

  full_subtractor u_fs (
    .x   (a_sr_reg[0]),
    .y   (b_sr_reg[0]),
    .bin (borrow_reg),
    .d   (fs_d),
    .bo  (fs_bo)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          diff_reg   <= {fs_d, diff_reg[WIDTH-1:1]};
          borrow_reg <= fs_bo;
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          if (last_bit) begin
            // Borrow into the MSB slice is borrow_reg; out of it is fs_bo.
            bout_reg  <= fs_bo;
            ovf_reg   <= borrow_reg ^ fs_bo;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
    int sx;
    int sy;
    int r;
    d  = x - y;
    bo = (int'(x) < int'(y));
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  // Model state: an accepted operation occupies edges acc_edge .. acc_edge+W+1;
  // the result appears (done) right after edge acc_edge+W.
  int           edge_cnt = 0;
  int           acc_edge = 0;
  int           next_ok  = 0;
  int           n_acc    = 0;
  bit           pend     = 0;
  logic [W-1:0] p_diff, last_diff;
  logic         p_bout, p_ovf, last_bout, last_ovf;

  initial begin
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    p_diff = '0; p_bout = 1'b0; p_ovf = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pend      = 0;
        next_ok   = 0;
        last_diff = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
      end else begin
        edge_cnt++;
        if (pend && edge_cnt == acc_edge + W) begin
          last_diff = p_diff;
          last_bout = p_bout;
          last_ovf  = p_ovf;
        end
        if (pend && edge_cnt == acc_edge + W + 1) pend = 0;
        if (start && edge_cnt >= next_ok) begin
          pend     = 1;
          acc_edge = edge_cnt;
          next_ok  = edge_cnt + W + 2;
          n_acc++;
          ref_sub(a, b, p_diff, p_bout, p_ovf);
        end
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  bit b2b_mode    = 0;
  int prev_done_e = -1;

  initial begin
    bit busy_exp;
    bit done_exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf",  ovf,  0);
      end else begin
        busy_exp = pend && (edge_cnt >= acc_edge) && (edge_cnt <= acc_edge + W);
        done_exp = pend && (edge_cnt == acc_edge + W);
        chk("cyc_busy", busy, busy_exp);
        chk("cyc_done", done, done_exp);
        if (!busy_exp || done_exp) begin
          chk("cyc_diff", diff, last_diff);
          chk("cyc_bout", bout, last_bout);
          chk("cyc_ovf",  ovf,  last_ovf);
        end
        if (done) begin
          if (b2b_mode && prev_done_e >= 0) chk("b2b_period", edge_cnt - prev_done_e, W + 2);
          prev_done_e = edge_cnt;
        end
      end
    end
  end

  // Directed op with literal expectations; operands are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string nm);
    int           busy_n;
    bit           seen;
    logic [W-1:0] md;
    logic         mb, mo;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv;
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_busy_cycles"}, busy_n, W + 1);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_bout"}, bout, eb);
    chk({nm, "_ovf"},  ovf,  eo);
    ref_sub(av, bv, md, mb, mo);
    chk({nm, "_model"}, {md, mb, mo}, {ed, eb, eo});
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
    $display("op %s: a=%02h b=%02h diff=%02h bout=%0b ovf=%0b", nm, av, bv, diff, bout, ovf);
  endtask

  initial begin
    int acc0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_flags", {bout, ovf}, 0);
    #1 rst = 1'b0;

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "v5a_23");
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "v10_20");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "v80_01");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "vff_ff");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "v00_ff");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "pre_rst");

    // Reset during the fourth SHIFT cycle.
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {bout, ovf}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (15) @(negedge clk);
    $display("op abort: reset mid-shift, no done expected");
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, "post_rst");

    // Start held high, operands changing every cycle.
    prev_done_e = -1;
    b2b_mode    = 1;
    acc0        = n_acc;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h23;
    for (int i = 0; i < 4 * (W + 2) - 1; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    b2b_mode = 0;
    chk("b2b_accepts", n_acc - acc0, 4);
    $display("op b2b: %0d operations accepted", n_acc - acc0);

    // Random operands with stray start/operand activity while busy.
    acc0 = n_acc;
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      start = 1'b1; a = 8'($urandom); b = 8'($urandom);
      for (int k = 0; k < W + 1; k++) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("rand_accepts", n_acc - acc0, 1000);
    $display("op random: %0d operations accepted", n_acc - acc0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
